// File: rtl/axi_lite_addr_router.sv
`default_nettype none
// =============================================================================
// Module   : axi_lite_addr_router
// Purpose  : Address-decoding AXI4-Lite router between the shared-bus arbiter
//            output and two downstream devices (dev0 = main SRAM, dev1 = MMIO).
//            One transaction in flight at a time. Requests that match neither
//            window are answered locally with DECERR and never reach a device.
// Ports    : clk            - clock
//            rst            - asynchronous reset, active low
//            up_*           - AXI4-Lite slave side (from arbiter)
//            dev0_*, dev1_* - AXI4-Lite master sides (to SRAM / MMIO)
// Revision : 1.0 - initial release
// =============================================================================
module axi_lite_addr_router #(
    parameter logic [31:0] DEV0_BASE = 32'h8000_0000,
    parameter logic [31:0] DEV0_MASK = 32'hF800_0000,
    parameter logic [31:0] DEV1_BASE = 32'hA000_0000,
    parameter logic [31:0] DEV1_MASK = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    // upstream (slave) side
    input  logic [31:0] up_awaddr,
    input  logic        up_awvalid,
    output logic        up_awready,
    input  logic [31:0] up_wdata,
    input  logic [3:0]  up_wstrb,
    input  logic        up_wvalid,
    output logic        up_wready,
    output logic [1:0]  up_bresp,
    output logic        up_bvalid,
    input  logic        up_bready,
    input  logic [31:0] up_araddr,
    input  logic        up_arvalid,
    output logic        up_arready,
    output logic [31:0] up_rdata,
    output logic [1:0]  up_rresp,
    output logic        up_rvalid,
    input  logic        up_rready,
    // device 0 (SRAM) master side
    output logic [31:0] dev0_awaddr,
    output logic        dev0_awvalid,
    input  logic        dev0_awready,
    output logic [31:0] dev0_wdata,
    output logic [3:0]  dev0_wstrb,
    output logic        dev0_wvalid,
    input  logic        dev0_wready,
    input  logic [1:0]  dev0_bresp,
    input  logic        dev0_bvalid,
    output logic        dev0_bready,
    output logic [31:0] dev0_araddr,
    output logic        dev0_arvalid,
    input  logic        dev0_arready,
    input  logic [31:0] dev0_rdata,
    input  logic [1:0]  dev0_rresp,
    input  logic        dev0_rvalid,
    output logic        dev0_rready,
    // device 1 (MMIO) master side
    output logic [31:0] dev1_awaddr,
    output logic        dev1_awvalid,
    input  logic        dev1_awready,
    output logic [31:0] dev1_wdata,
    output logic [3:0]  dev1_wstrb,
    output logic        dev1_wvalid,
    input  logic        dev1_wready,
    input  logic [1:0]  dev1_bresp,
    input  logic        dev1_bvalid,
    output logic        dev1_bready,
    output logic [31:0] dev1_araddr,
    output logic        dev1_arvalid,
    input  logic        dev1_arready,
    input  logic [31:0] dev1_rdata,
    input  logic [1:0]  dev1_rresp,
    input  logic        dev1_rvalid,
    output logic        dev1_rready
);

    localparam logic [1:0] c_SEL_DEV0    = 2'd0;
    localparam logic [1:0] c_SEL_DEV1    = 2'd1;
    localparam logic [1:0] c_SEL_NONE    = 2'd2;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_ERR_R   = 3'd5,
        S_ERR_B   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_sel;
    logic        r_aw_done;
    logic        r_w_done;

    logic [1:0]  w_ar_sel;
    logic [1:0]  w_aw_sel;
    logic        w_rd_accept;
    logic        w_wr_accept;
    logic        w_wr_both;

    // generic channel controls, routed to the selected device below
    logic        w_ar_v;
    logic        w_r_rdy;
    logic        w_aw_v;
    logic        w_w_v;
    logic        w_b_rdy;

    // responses from whichever device is currently selected
    logic        w_sel1;
    logic        w_dev_arready;
    logic        w_dev_rvalid;
    logic [31:0] w_dev_rdata;
    logic [1:0]  w_dev_rresp;
    logic        w_dev_awready;
    logic        w_dev_wready;
    logic        w_dev_bvalid;
    logic [1:0]  w_dev_bresp;

    // dev0 is tested first so it wins if both windows overlap
    function automatic logic [1:0] f_decode(input logic [31:0] addr);
        logic [1:0] sel;
        if ((addr & DEV0_MASK) == DEV0_BASE) begin
            sel = c_SEL_DEV0;
        end else if ((addr & DEV1_MASK) == DEV1_BASE) begin
            sel = c_SEL_DEV1;
        end else begin
            sel = c_SEL_NONE;
        end
        return sel;
    endfunction

    assign w_ar_sel = f_decode(up_araddr);
    assign w_aw_sel = f_decode(up_awaddr);

    // routing depends only on the latched selection
    assign w_sel1        = (r_sel == c_SEL_DEV1);
    assign w_dev_arready = w_sel1 ? dev1_arready : dev0_arready;
    assign w_dev_rvalid  = w_sel1 ? dev1_rvalid  : dev0_rvalid;
    assign w_dev_rdata   = w_sel1 ? dev1_rdata   : dev0_rdata;
    assign w_dev_rresp   = w_sel1 ? dev1_rresp   : dev0_rresp;
    assign w_dev_awready = w_sel1 ? dev1_awready : dev0_awready;
    assign w_dev_wready  = w_sel1 ? dev1_wready  : dev0_wready;
    assign w_dev_bvalid  = w_sel1 ? dev1_bvalid  : dev0_bvalid;
    assign w_dev_bresp   = w_sel1 ? dev1_bresp   : dev0_bresp;

    // write request is finished once each channel has been (or is now) accepted
    assign w_wr_both = (r_aw_done || w_dev_awready) && (r_w_done || w_dev_wready);

    // -------------------------------------------------------------------------
    // next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nx  = r_state;
        up_arready  = 1'b0;
        up_awready  = 1'b0;
        up_wready   = 1'b0;
        up_rvalid   = 1'b0;
        up_rdata    = 32'h0;
        up_rresp    = 2'b00;
        up_bvalid   = 1'b0;
        up_bresp    = 2'b00;
        w_ar_v      = 1'b0;
        w_r_rdy     = 1'b0;
        w_aw_v      = 1'b0;
        w_w_v       = 1'b0;
        w_b_rdy     = 1'b0;
        w_rd_accept = 1'b0;
        w_wr_accept = 1'b0;

        case (r_state)
            S_IDLE: begin
                // readies are gated by rst because the reset is asynchronous
                // and the state already sits in IDLE while reset is held
                up_arready = rst;
                // a write is taken only with AW and W together and no read
                // competing; otherwise AW/W stay pending upstream
                up_awready = rst && !up_arvalid && up_awvalid && up_wvalid;
                up_wready  = up_awready;
                if (up_arvalid) begin
                    w_rd_accept = 1'b1;
                    w_state_nx  = (w_ar_sel == c_SEL_NONE) ? S_ERR_R : S_RD_ADDR;
                end else if (up_awvalid && up_wvalid) begin
                    w_wr_accept = 1'b1;
                    w_state_nx  = (w_aw_sel == c_SEL_NONE) ? S_ERR_B : S_WR_REQ;
                end
            end

            S_RD_ADDR: begin
                w_ar_v = 1'b1;
                if (w_dev_arready) begin
                    w_state_nx = S_RD_DATA;
                end
            end

            S_RD_DATA: begin
                up_rvalid = w_dev_rvalid;
                up_rdata  = w_dev_rdata;
                up_rresp  = w_dev_rresp;
                w_r_rdy   = up_rready;
                if (w_dev_rvalid && up_rready) begin
                    w_state_nx = S_IDLE;
                end
            end

            S_WR_REQ: begin
                w_aw_v = !r_aw_done;
                w_w_v  = !r_w_done;
                if (w_wr_both) begin
                    w_state_nx = S_WR_RESP;
                end
            end

            S_WR_RESP: begin
                up_bvalid = w_dev_bvalid;
                up_bresp  = w_dev_bresp;
                w_b_rdy   = up_bready;
                if (w_dev_bvalid && up_bready) begin
                    w_state_nx = S_IDLE;
                end
            end

            S_ERR_R: begin
                up_rvalid = 1'b1;
                up_rresp  = c_RESP_DECERR;
                if (up_rready) begin
                    w_state_nx = S_IDLE;
                end
            end

            S_ERR_B: begin
                up_bvalid = 1'b1;
                up_bresp  = c_RESP_DECERR;
                if (up_bready) begin
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // device-side routing: payload is always the latched copy, valids/readies
    // only reach the selected device
    // -------------------------------------------------------------------------
    assign dev0_araddr  = r_addr;
    assign dev0_awaddr  = r_addr;
    assign dev0_wdata   = r_wdata;
    assign dev0_wstrb   = r_wstrb;
    assign dev0_arvalid = w_ar_v  && (r_sel == c_SEL_DEV0);
    assign dev0_rready  = w_r_rdy && (r_sel == c_SEL_DEV0);
    assign dev0_awvalid = w_aw_v  && (r_sel == c_SEL_DEV0);
    assign dev0_wvalid  = w_w_v   && (r_sel == c_SEL_DEV0);
    assign dev0_bready  = w_b_rdy && (r_sel == c_SEL_DEV0);

    assign dev1_araddr  = r_addr;
    assign dev1_awaddr  = r_addr;
    assign dev1_wdata   = r_wdata;
    assign dev1_wstrb   = r_wstrb;
    assign dev1_arvalid = w_ar_v  && (r_sel == c_SEL_DEV1);
    assign dev1_rready  = w_r_rdy && (r_sel == c_SEL_DEV1);
    assign dev1_awvalid = w_aw_v  && (r_sel == c_SEL_DEV1);
    assign dev1_wvalid  = w_w_v   && (r_sel == c_SEL_DEV1);
    assign dev1_bready  = w_b_rdy && (r_sel == c_SEL_DEV1);

    // -------------------------------------------------------------------------
    // state and latched request registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
            r_sel     <= c_SEL_NONE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;

            if (w_rd_accept) begin
                r_addr <= up_araddr;
                r_sel  <= w_ar_sel;
            end else if (w_wr_accept) begin
                r_addr  <= up_awaddr;
                r_wdata <= up_wdata;
                r_wstrb <= up_wstrb;
                r_sel   <= w_aw_sel;
            end

            if (r_state == S_WR_REQ) begin
                if (w_wr_both) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end else begin
                    if (w_dev_awready) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_dev_wready) begin
                        r_w_done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_addr_router.md
Name: axi_lite_addr_router

Overview:
- Address-decoding router placed between the shared-bus arbiter output (IFU/LSU already merged) and two downstream devices.
- Device 0 is main SRAM. Device 1 is the MMIO block (UART/CLINT).
- Handles exactly one AXI4-Lite transaction in flight.
- Requests to unmapped addresses get an internally generated DECERR response and never reach either device.

Parameters:
- DEV0_BASE, 32'h8000_0000, device 0 base; match when (addr & DEV0_MASK) == DEV0_BASE
- DEV0_MASK, 32'hF800_0000, device 0 match mask (128 MiB window)
- DEV1_BASE, 32'hA000_0000, device 1 base
- DEV1_MASK, 32'hFFFF_0000, device 1 match mask (64 KiB window)

Ports:
- clk  input  1  clock
- rst  input  1  reset; one clock, asynchronous, active-low (asserted when 0)
- up_if  AXI4_Lite.slave  32b addr/data, 4b wstrb, 2b resp  request from arbiter
- dev0_if  AXI4_Lite.master  same  SRAM
- dev1_if  AXI4_Lite.master  same  MMIO

Behaviour:
- State register, reset IDLE.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, ERR_R, ERR_B.
- Latched registers: addr, wdata, wstrb, sel (0 = dev0, 1 = dev1, 2 = none), aw_done, w_done.
- Reset (rst=0, async): state=IDLE. Every output valid is 0. up_if arready/awready/wready are 0 while rst=0. Output data/addr registers are cleared to 0.

Upstream acceptance:
- IDLE only: up arready=1, awready=wready=1. All ready outputs are 0 in every other state.
- Read accept: arvalid=1. Latch araddr and decoded sel. Go to RD_ADDR, or ERR_R if sel=none.
- Write accept: arvalid=0, awvalid=1 and wvalid=1 in the same cycle. Latch awaddr, wdata, wstrb. Go to WR_REQ, or ERR_B if sel=none.
- Simultaneous arvalid and awvalid: the read wins; the write stays pending upstream.
- awvalid without wvalid: not accepted; awready and wready are forced to 0 in that cycle.
- If both DEV0 and DEV1 match, dev0 wins.

Read path:
- RD_ADDR: selected device gets arvalid=1 and araddr=latched addr, starting the cycle after accept. Hold until that device's arready=1, then go to RD_DATA.
- RD_DATA: selected device rvalid/rdata/rresp pass combinationally to up_if. Up rready passes to the device. On rvalid&&rready, go to IDLE.
- Unselected device sees arvalid=0 and rready=0.

Write path:
- WR_REQ: selected device gets awvalid=!aw_done and wvalid=!w_done. Set aw_done on awready and w_done on wready; the two may complete in either order or the same cycle.
- When both are done (including same-cycle completion), clear the flags and go to WR_RESP.
- WR_RESP: bvalid/bresp pass through from the selected device, bready passes through from up_if. On fire, go to IDLE.

Error path:
- ERR_R: up rvalid=1, rdata=32'h0, rresp=2'b11. On rready, go to IDLE.
- ERR_B: up bvalid=1, bresp=2'b11. On bready, go to IDLE.
- Neither device sees any valid in these states.

Timing and general rules:
- Minimum latency, accept to response valid with zero-wait device: 2 cycles (addr issue, data return).
- Routing uses the latched sel only, never live up_if addresses.
- Once latched, addr/wdata/wstrb stay stable on device ports until the handshake completes.
- Response valids reaching up_if outside RD_DATA/WR_RESP/ERR_* are 0.
- Reset asserted mid-transaction: state goes to IDLE immediately. Device valids drop asynchronously. No response is generated.

Test Plan:
- Read 0x8000_0010; dev0 arready after 1 cycle, rdata=32'hDEAD_BEEF, rresp=0 -> up rvalid with DEAD_BEEF/OKAY; dev1 arvalid never asserts; state returns to IDLE.
- Write 0xA000_03F8, wdata=32'h41, wstrb=4'b0001; dev1 wready 2 cycles before awready -> exactly one AW and one W handshake on dev1; bresp OKAY forwarded; dev0 untouched.
- Read 0x0000_1000 (unmapped) -> no device valid; up rvalid=1, rresp=2'b11, rdata=0; rready held low 3 cycles -> response held stable.
- Same cycle arvalid(0x8000_0000) and awvalid+wvalid(0x8000_0004) -> read accepted, awready=0; write accepted on the next IDLE after r fire.
- awvalid=1, wvalid=0 for 4 cycles, then wvalid=1 -> awready=0 during the 4 cycles; accepted on cycle 5.
- Assert rst=0 while in RD_DATA with dev0 rvalid pending -> up rvalid and dev0 arvalid/rready are 0 in the same cycle; after release, a fresh read to dev1 completes normally.
